// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_pkg
// Description : Shared types and constants for the FP16 multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_pkg;

    localparam int FP16_W = 16;

    // Canonical quiet NaN returned when an operation is abandoned.
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_mult_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches upward from ptr
//               with wrap-around and returns a one-hot grant plus its index.
//               Nothing is granted while 'any' is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             any,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx
);

    logic w_found;
    int   w_j;

    // First set request at or above ptr, wrapping past N_REQ-1 back to 0.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (any && !w_found && req[w_j]) begin
                w_found    = 1'b1;
                grant[w_j] = 1'b1;
                idx        = PTR_W'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : fp16_mult_sched
// Description : Round-robin scheduler sharing one sequential FP16 multiplier
//               among N_REQ requesters. One operation in flight at a time;
//               a timed-out operation returns a quiet NaN with an error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_mult_sched
    import fp16_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*FP16_W-1:0]    req_a,
    input  logic [N_REQ*FP16_W-1:0]    req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       mul_start,
    output logic [FP16_W-1:0]          mul_a,
    output logic [FP16_W-1:0]          mul_b,
    input  logic                       mul_done,
    input  logic [FP16_W-1:0]          mul_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [FP16_W-1:0]          rsp_product,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    sched_state_t        r_state;
    sched_state_t        w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [TIMER_W-1:0]  r_timer;

    logic [N_REQ-1:0]    w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_pick_en;
    logic                w_accept;
    logic                w_done_hit;
    logic                w_timeout_hit;
    logic                w_rsp_hs;

    logic [FP16_W-1:0]   w_a_arr [N_REQ];
    logic [FP16_W-1:0]   w_b_arr [N_REQ];

    // Split the packed operand buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*FP16_W +: FP16_W];
            assign w_b_arr[gi] = req_b[gi*FP16_W +: FP16_W];
        end
    endgenerate

    // Grants are only offered in IDLE, and never while reset is held.
    assign w_pick_en = (r_state == IDLE) && !rst;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .any   (w_pick_en),
        .grant (w_grant),
        .idx   (w_grant_idx)
    );

    assign req_ready     = w_grant;
    assign w_accept      = |w_grant;
    assign w_done_hit    = (r_state == WAIT) && mul_done;
    // Done takes priority over an expiring timer in the same cycle.
    assign w_timeout_hit = (r_state == WAIT) && !mul_done &&
                           (r_timer == TIMER_W'(TIMEOUT - 1));
    assign w_rsp_hs      = (r_state == RESPOND) && rsp_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (w_done_hit || w_timeout_hit) w_next_state = RESPOND;
            RESPOND: if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Wait timer: cleared in ISSUE, counts in WAIT, saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_state == ISSUE) begin
            r_timer <= '0;
        end else if ((r_state == WAIT) && (r_timer != TIMER_W'(TIMEOUT))) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Round-robin pointer advances past the owner once its response is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_rsp_hs) begin
            if (rsp_id == ID_W'(N_REQ - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= rsp_id + 1'b1;
            end
        end
    end

    // Operand and response capture; operands stay put from ISSUE through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            if (w_accept) begin
                mul_a  <= w_a_arr[w_grant_idx];
                mul_b  <= w_b_arr[w_grant_idx];
                rsp_id <= w_grant_idx;
            end
            if (w_done_hit) begin
                rsp_product <= mul_result;
            end else if (w_timeout_hit) begin
                rsp_product <= FP16_QNAN;
            end
        end
    end

    // Registered control outputs, derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mul_start   <= w_accept;
            rsp_valid   <= (w_next_state == RESPOND);
            timeout_err <= w_timeout_hit;
            busy        <= (w_next_state != IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_mult_sched
// Description : Scoreboard bench for fp16_mult_sched with a scripted core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_mult_sched;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*16-1:0] req_a = '0;
    logic [N*16-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic            mul_start;
    logic [15:0]     mul_a, mul_b;
    logic            mul_done;
    logic [15:0]     mul_result;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_product;
    logic            timeout_err;
    logic            busy;

    fp16_mult_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] prod;
        logic        to;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    logic [15:0] op_a [N];
    logic [15:0] op_b [N];
    logic [15:0] exp_prod [N];
    int          cur_lat = 0;
    logic        cur_to  = 1'b0;
    int          last_acc_cyc = -100;
    int          last_acc_id  = 0;
    logic        prev_valid   = 1'b0;

    // Core model: done fires core_delay cycles after start; 0 means never.
    int          core_delay = 0;
    int          core_cnt   = 0;
    logic        core_use_a = 1'b0;
    logic [15:0] core_res   = '0;

    initial begin
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (rst) begin
                core_cnt = 0;
            end else begin
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        mul_done   = 1'b1;
                        // Echoing operand a makes each requester's result distinct.
                        mul_result = core_use_a ? mul_a : core_res;
                    end
                end
                if (mul_start && core_delay > 0) core_cnt = core_delay;
            end
        end
    end

    // Monitor: records accepts (pushing expectations), checks starts and responses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        grant_log.push_back(i);
                        last_acc_cyc = cyc;
                        last_acc_id  = i;
                        sb.push_back('{i, exp_prod[i], cur_to, cyc + cur_lat});
                    end
                end
                if (mul_start) begin
                    chk("start_cycle", cyc, last_acc_cyc + 1);
                    chk("mul_a", int'(mul_a), int'(op_a[last_acc_id]));
                    chk("mul_b", int'(mul_b), int'(op_b[last_acc_id]));
                end
                if (rsp_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id %0d product 0x%0h, expected no response", rsp_id, rsp_product);
                    end else begin
                        chk("rsp_cycle", cyc, sb[0].cyc);
                        chk("timeout_err", int'(timeout_err), int'(sb[0].to));
                    end
                end else if (timeout_err) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_timeout_err: got 1, expected 0 (cycle %0d)", cyc);
                end
                if (rsp_valid && rsp_ready && sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_product", int'(rsp_product), int'(e.prod));
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] p);
        op_a[id] = a;
        op_b[id] = b;
        exp_prod[id] = p;
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
    endtask

    // Returns at the negedge after the n-th logged grant has been transferred.
    task automatic wait_grants(input int n);
        int b = 0;
        while (grant_log.size() < n && b < 300) begin
            @(negedge clk);
            #2;
            b++;
        end
        if (grant_log.size() < n) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: got %0d grants, expected %0d", grant_log.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int b = 0;
        while (sb.size() > 0 && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_wait: got %0d pending responses, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        core_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   int'(req_ready),   0);
        chk({tag, "_mul_start"},   int'(mul_start),   0);
        chk({tag, "_mul_a"},       int'(mul_a),       0);
        chk({tag, "_mul_b"},       int'(mul_b),       0);
        chk({tag, "_rsp_valid"},   int'(rsp_valid),   0);
        chk({tag, "_rsp_id"},      int'(rsp_id),      0);
        chk({tag, "_rsp_product"}, int'(rsp_product), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
        chk({tag, "_busy"},        int'(busy),        0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ord_a [6] = '{0, 1, 2, 3, 0, 1};
        int ord_b [4] = '{0, 1, 3, 0};
        int hold_id;
        int hold_p;

        for (int i = 0; i < N; i++) set_op(i, 16'h0, 16'h0, 16'h0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single operation: 1.0 x 2.0 on requester 1, done 5 cycles after start
        set_op(1, 16'h3C00, 16'h4000, 16'h4000);
        core_use_a = 1'b0; core_res = 16'h4000; core_delay = 5;
        cur_lat = 7; cur_to = 1'b0;
        base = grant_log.size();
        req_valid = 4'b0010;
        wait_grants(base + 1);
        req_valid = '0;
        wait_drain();

        // Round-robin fairness, all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 16'h1000 + 16'(i), 16'h3C00, 16'h1000 + 16'(i));
        core_use_a = 1'b1; core_delay = 2; cur_lat = 4; cur_to = 1'b0;
        base = grant_log.size();
        req_valid = 4'b1111;
        wait_grants(base + 6);
        req_valid = '0;
        wait_drain();
        for (int k = 0; k < 6; k++) chk("rr_order_all", grant_log[base + k], ord_a[k]);

        // Round-robin with requester 2 dropping out after the first round
        do_reset();
        base = grant_log.size();
        req_valid = 4'b1111;
        wait_grants(base + 4);
        req_valid[2] = 1'b0;
        wait_grants(base + 8);
        req_valid = '0;
        wait_drain();
        for (int k = 0; k < 4; k++) chk("rr_order_drop2", grant_log[base + 4 + k], ord_b[k]);

        // Timeout: core never completes
        set_op(0, 16'h4200, 16'h4400, 16'h7E00);
        core_use_a = 1'b0; core_delay = 0; cur_lat = TO + 2; cur_to = 1'b1;
        base = grant_log.size();
        req_valid = 4'b0001;
        wait_grants(base + 1);
        req_valid = '0;
        for (int k = 0; k < TO + 1; k++) begin
            #1;
            chk("timeout_busy", int'(busy), 1);
            @(negedge clk);
        end
        #1;
        chk("timeout_idle_busy", int'(busy), 0);
        core_cnt = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("late_done_rsp_valid", int'(rsp_valid), 0);
            chk("late_done_busy", int'(busy), 0);
        end

        // Response backpressure with requesters 0 and 3 contending
        do_reset();
        set_op(0, 16'h3C00, 16'h3C00, 16'h3C00);
        set_op(3, 16'hBC00, 16'h4000, 16'hBC00);
        core_use_a = 1'b1; core_delay = 3; cur_lat = 5; cur_to = 1'b0;
        rsp_ready = 1'b0;
        base = grant_log.size();
        req_valid = 4'b1001;
        wait_grants(base + 1);
        chk("bp_first_grant", grant_log[base], 0);
        begin
            int b = 0;
            while (!rsp_valid && b < 50) begin
                @(negedge clk);
                #1;
                b++;
            end
        end
        hold_id = 0;
        hold_p  = 16'h3C00;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_id", int'(rsp_id), hold_id);
            chk("bp_rsp_product", int'(rsp_product), hold_p);
            chk("bp_req_ready", int'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_grants(base + 2);
        chk("bp_next_grant", grant_log[base + 1], 3);
        req_valid = '0;
        wait_drain();

        // Done arriving in the same cycle the timer expires: -5.0 wins, no error
        set_op(1, 16'h4500, 16'hBC00, 16'hC500);
        core_use_a = 1'b0; core_res = 16'hC500; core_delay = TO; cur_lat = TO + 2; cur_to = 1'b0;
        base = grant_log.size();
        req_valid = 4'b0010;
        wait_grants(base + 1);
        req_valid = '0;
        wait_drain();

        // Reset while in WAIT: operation lost, then requester 2 wins from pointer 0
        set_op(1, 16'h4000, 16'h4000, 16'h4400);
        core_use_a = 1'b0; core_res = 16'h4400; core_delay = 6; cur_lat = 8; cur_to = 1'b0;
        base = grant_log.size();
        req_valid = 4'b0010;
        wait_grants(base + 1);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        core_cnt = 0;
        #1;
        chk_reset_outputs("midwait");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        set_op(2, 16'h4800, 16'h3800, 16'h4800);
        set_op(3, 16'h4A00, 16'h3800, 16'h4A00);
        core_use_a = 1'b1; core_delay = 2; cur_lat = 4;
        base = grant_log.size();
        req_valid = 4'b1100;
        wait_grants(base + 1);
        req_valid = '0;
        chk("post_reset_grant", grant_log[base], 2);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_mult_sched.md
# fp16_mult_sched

Round-robin scheduler that shares one multi-cycle half-precision multiplier core among `N_REQ` requesters. Each requester hands over an FP16 operand pair with a valid/ready handshake. The scheduler issues a one-cycle start to the core, waits for its done strobe (bounded by a timeout), then returns the product tagged with the requester index. It sits between the FPU issue logic and the sequential FP16 multiplier, and is the only block that drives the core's start and operands.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, max cycles spent in WAIT before the operation is abandoned (≥2)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in N_REQ: per-requester operand pair valid
- `req_a`, `req_b` in N_REQ*16: packed operands; requester i uses bits [16i+15:16i]
- `req_ready` out N_REQ: one-hot accept; a transfer happens on a cycle where `req_valid[i] & req_ready[i]`
- `mul_start` out 1: one-cycle start pulse to the core
- `mul_a`, `mul_b` out 16: operands to the core, held stable from ISSUE through WAIT
- `mul_done` in 1: core completion strobe
- `mul_result` in 16: core product, valid while `mul_done`=1
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response accepted
- `rsp_id` out $clog2(N_REQ): index of the requester that owns the response
- `rsp_product` out 16: FP16 result
- `timeout_err` out 1: one-cycle pulse when an operation times out
- `busy` out 1: high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit searching upward from `rr_ptr` with wrap-around.
  - `req_ready[grant]` is combinational and asserted only in IDLE.
  - Latch `req_a`/`req_b` of the grant into `mul_a`/`mul_b`, latch the grant into `rsp_id`, then go to ISSUE.
- **ISSUE**
  - `mul_start`=1 for exactly this cycle.
  - Clear the timer, then go to WAIT.
- **WAIT**
  - The timer increments every cycle.
  - If `mul_done`=1: latch `mul_result` into `rsp_product` and go to RESPOND.
  - Else, if timer == TIMEOUT-1: set `rsp_product`=16'h7E00 (canonical qNaN), pulse `timeout_err` on the next cycle, and go to RESPOND.
  - If `mul_done` and timeout occur in the same cycle, done wins and there is no error.
- **RESPOND**
  - `rsp_valid`=1, with `rsp_id`/`rsp_product` stable until `rsp_ready`=1.
  - On handshake: `rr_ptr` = (`rsp_id`+1) mod N_REQ, then go to IDLE.
- `mul_done` is ignored outside WAIT.
- A requester deasserting `req_valid` without handshake is legal and nothing is latched for it.
- The scheduler does no arithmetic. Special values (NaN/Inf/zero) are passed through exactly as produced by the core.
- Timer width is $clog2(TIMEOUT+1) and it never wraps.
- **Reset mid-operation:** the state returns to IDLE and any in-flight operation is lost with no response. The core must share the same `rst`.
- **Reset values:**
  - `req_ready`=0, `mul_start`=0, `mul_a`=`mul_b`=0
  - `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0
  - `timeout_err`=0, `busy`=0
  - `rr_ptr`=0, state IDLE

## Timing
- Request accepted in cycle T.
- `mul_start` in T+1; WAIT begins at T+2.
- If `mul_done` is sampled in cycle D, `rsp_valid` rises at D+1.
- For a core whose done arrives k cycles after start: `rsp_valid` at T+1+k+1.
- Timeout: `rsp_valid` at T+2+TIMEOUT; `timeout_err` is high in that same cycle.
- Back-to-back: `rsp_ready` held high gives one IDLE cycle between operations, so the next accept is at the cycle after the response handshake.
- At most one operation is outstanding. `req_ready` is 0 in ISSUE, WAIT and RESPOND.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, `rr_ptr` and state.

## Structure
- Shared package `fp16_pkg` holds:
  - `sched_state_t` enum (IDLE, ISSUE, WAIT, RESPOND)
  - `FP16_W`=16
  - `FP16_QNAN`=16'h7E00
- Sub-module `rr_pick`: purely combinational; takes `req` (N_REQ), `ptr`, `any` and produces a one-hot `grant` and an encoded index.
- The top holds the FSM, timer, operand/response registers and `rr_ptr`.

## Test plan
- **Single operation:** requester 1 sends 16'h3C00 × 16'h4000 (1.0×2.0); the bench core model asserts done 5 cycles after start with 16'h4000.
  - Expect `mul_start` at T+1, `rsp_valid` at T+7, `rsp_id`=1, `rsp_product`=16'h4000, `timeout_err`=0.
- **Round-robin fairness:** all four `req_valid` held high and `rsp_ready`=1.
  - Expect grant order 0,1,2,3,0,1.
  - Dropping `req_valid[2]` after the first round gives order 0,1,3,0.
- **Timeout:** TIMEOUT=8 and the core never asserts done.
  - Expect `rsp_product`=16'h7E00, a one-cycle `timeout_err`, `rsp_valid` at T+10, `busy` throughout.
  - A late `mul_done` in IDLE is ignored.
- **Response backpressure:** `rsp_ready` held low for 10 cycles while req 0 and req 3 are both valid.
  - Expect `rsp_valid`/`rsp_id`/`rsp_product` stable and `req_ready`=0 throughout.
  - After the handshake, req 3 is granted next.
- **Done/timeout collision:** done is asserted exactly in the timer==TIMEOUT-1 cycle with result 16'hC500.
  - Expect `rsp_product`=16'hC500 and no `timeout_err`.
- **Reset mid-WAIT:** assert `rst` for 1 cycle during WAIT.
  - Expect all outputs at reset values immediately (asynchronous) and no response for the lost operation.
  - The next request from requester 2 is granted (`rr_ptr`=0 search).
